// File: rtl/serial_in_scanner_pkg.sv
// Shared types and board constants for the 74LV165 switch-chain scanner.
package serial_in_scanner_pkg;

  // Scanner sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StLow,
    StHigh
  } scan_state_e;

  // Board map: which serial lane carries which panel field.
  localparam int unsigned LANE_REG_C_LO = 0;
  localparam int unsigned LANE_REG_C_HI = 1;
  localparam int unsigned LANE_SEL      = 2;
  localparam int unsigned LANE_STRT_HI  = 3;
  localparam int unsigned LANE_CMP      = 4;

  // Panel field widths carried across the lanes.
  localparam int unsigned REG_C_W = 31;
  localparam int unsigned STRT_W  = 12;
  localparam int unsigned SEL_W   = 12;
  localparam int unsigned CMP_W   = 12;

endpackage

// File: rtl/serial_in_scanner_if.sv
// Bundle between the scanner, the off-board 165 chains and the panel logic.
interface serial_in_scanner_if #(
  parameter int unsigned LANES = 5,
  parameter int unsigned BITS  = 16
);
  logic                    scan_en;
  logic [LANES-1:0]        serial_in_ser;
  logic                    serial_in_shldn;
  logic                    serial_in_rclk;
  logic [LANES*BITS-1:0]   data_out;
  logic                    data_valid;
  logic                    busy;

  // Scanner side.
  modport master (
    input  scan_en,
    input  serial_in_ser,
    output serial_in_shldn,
    output serial_in_rclk,
    output data_out,
    output data_valid,
    output busy
  );

  // Chain / consumer side.
  modport slave (
    output scan_en,
    output serial_in_ser,
    input  serial_in_shldn,
    input  serial_in_rclk,
    input  data_out,
    input  data_valid,
    input  busy
  );
endinterface

// File: rtl/serial_phase_timer.sv
// Loadable down-counter timing one CLK_DIV-long phase; phase_done marks its last cycle.
module serial_phase_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic reload,
  output logic phase_done
);
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Reload at each phase start, then count down and hold at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (reload) begin
      cnt_q <= CntMax;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign phase_done = (cnt_q == '0);

endmodule

// File: rtl/serial_in_scanner.sv
// Drives shldn/rclk for the 165 chains and captures LANES MSB-first serial words.
module serial_in_scanner
  import serial_in_scanner_pkg::*;
#(
  parameter int unsigned LANES   = 5,
  parameter int unsigned BITS    = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input logic                 clk,
  input logic                 resetn,
  serial_in_scanner_if.master bus
);
  localparam int unsigned BitW = $clog2(BITS);
  localparam logic [BitW-1:0] LastBit = BitW'(BITS - 1);

  scan_state_e     state_q, state_d;
  logic [BitW-1:0] bit_cnt_q;
  logic            phase_done;
  logic            reload;
  logic            sample;
  logic            last_sample;
  logic            rclk_q, shldn_q, busy_q, valid_q;

  serial_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .reload     (reload),
    .phase_done (phase_done)
  );

  // Next state; sampling happens on the last cycle of each LOW phase.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    unique case (state_q)
      // Skip the completion cycle so back-to-back scans leave one extra idle cycle.
      StIdle: if (bus.scan_en && !valid_q) state_d = StLoad;
      StLoad: if (phase_done) state_d = StLow;
      StLow: begin
        if (phase_done) begin
          sample  = 1'b1;
          state_d = (bit_cnt_q == LastBit) ? StIdle : StHigh;
        end
      end
      StHigh: if (phase_done) state_d = StLow;
      default: state_d = StIdle;
    endcase
  end

  assign reload      = (state_d != state_q);
  assign last_sample = sample && (bit_cnt_q == LastBit);

  // State, bit counter and registered chain-control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rclk_q    <= 1'b0;
      shldn_q   <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rclk_q  <= (state_d == StHigh);
      shldn_q <= (state_d != StLoad);
      busy_q  <= (state_d != StIdle);
      valid_q <= last_sample;
      if (state_d == StLoad) begin
        bit_cnt_q <= '0;
      end else if (sample) begin
        bit_cnt_q <= last_sample ? '0 : bit_cnt_q + BitW'(1);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    // Only BITS-1 bits need holding; the final bit goes straight into data.
    logic [BITS-2:0] shift_q;
    logic [BITS-1:0] data_q;

    // Shift each sample in at the LSB; publish the whole word on the last one.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        shift_q <= '0;
        data_q  <= '0;
      end else if (sample) begin
        shift_q <= (BITS-1)'({shift_q, bus.serial_in_ser[l]});
        if (last_sample) begin
          data_q <= {shift_q, bus.serial_in_ser[l]};
        end
      end
    end

    assign bus.data_out[l*BITS +: BITS] = data_q;
  end

  assign bus.serial_in_rclk  = rclk_q;
  assign bus.serial_in_shldn = shldn_q;
  assign bus.busy            = busy_q;
  assign bus.data_valid      = valid_q;

endmodule

// File: tb/tb_serial_in_scanner.sv
// Scoreboard bench: two scanners (CLK_DIV 2 and 1) reading behavioural 165 chains.
module tb_serial_in_scanner;
  import serial_in_scanner_pkg::*;

  localparam int unsigned LANES = 5;
  localparam int unsigned BITS  = 16;
  localparam int unsigned W     = LANES * BITS;

  typedef struct packed {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q1[$];
  exp_t q2[$];

  logic [BITS-1:0]  par1[LANES];
  logic [BITS-1:0]  par2[LANES];
  logic [BITS-1:0]  chain1[LANES];
  logic [BITS-1:0]  chain2[LANES];
  logic [LANES-1:0] ser1 = '0;
  logic [LANES-1:0] ser2 = '0;
  logic             rprev1 = 1'b0;
  logic             rprev2 = 1'b0;
  int rises1 = 0, rises2 = 0, shl_low1 = 0, shl_low2 = 0;
  int overlap1 = 0, overlap2 = 0, unstable1 = 0, unstable2 = 0;
  logic [W-1:0] prev1 = '0;
  logic [W-1:0] prev2 = '0;

  serial_in_scanner_if #(.LANES(LANES), .BITS(BITS)) bus1 ();
  serial_in_scanner_if #(.LANES(LANES), .BITS(BITS)) bus2 ();

  serial_in_scanner #(.LANES(LANES), .BITS(BITS), .CLK_DIV(2)) dut1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus1)
  );

  serial_in_scanner #(.LANES(LANES), .BITS(BITS), .CLK_DIV(1)) dut2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus2)
  );

  assign bus1.serial_in_ser = ser1;
  assign bus2.serial_in_ser = ser2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // 74LV165 chain models: load while shldn low, shift on rclk rise, QH = MSB.
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < LANES; l++) begin
      if (!bus1.serial_in_shldn) chain1[l] = par1[l];
      else if (bus1.serial_in_rclk && !rprev1) chain1[l] = {chain1[l][BITS-2:0], 1'b0};
      ser1[l] = chain1[l][BITS-1];
    end
    if (bus1.serial_in_rclk && !rprev1) rises1++;
    rprev1 = bus1.serial_in_rclk;
  end

  always @(posedge clk) begin
    #1;
    for (int l = 0; l < LANES; l++) begin
      if (!bus2.serial_in_shldn) chain2[l] = par2[l];
      else if (bus2.serial_in_rclk && !rprev2) chain2[l] = {chain2[l][BITS-2:0], 1'b0};
      ser2[l] = chain2[l][BITS-1];
    end
    if (bus2.serial_in_rclk && !rprev2) rises2++;
    rprev2 = bus2.serial_in_rclk;
  end

  // Monitors: pop an expectation on every data_valid.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.serial_in_rclk && !bus1.serial_in_shldn) overlap1++;
    if (!bus1.serial_in_shldn) shl_low1++;
    if (bus1.data_valid) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected data_valid", W'(bus1.data_valid), '0);
      end else begin
        e = q1.pop_front();
        check("dut1 data_out", bus1.data_out, e.data);
        check("dut1 data_valid cycle", W'(cyc), W'(e.cyc));
      end
    end else if (resetn && bus1.data_out !== prev1) begin
      unstable1++;
    end
    prev1 = bus1.data_out;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus2.serial_in_rclk && !bus2.serial_in_shldn) overlap2++;
    if (!bus2.serial_in_shldn) shl_low2++;
    if (bus2.data_valid) begin
      if (q2.size() == 0) begin
        check("dut2 unexpected data_valid", W'(bus2.data_valid), '0);
      end else begin
        e = q2.pop_front();
        check("dut2 data_out", bus2.data_out, e.data);
        check("dut2 data_valid cycle", W'(cyc), W'(e.cyc));
      end
    end else if (resetn && bus2.data_out !== prev2) begin
      unstable2++;
    end
    prev2 = bus2.data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [W-1:0] pack1();
    logic [W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*BITS +: BITS] = par1[l];
    return v;
  endfunction

  function automatic logic [W-1:0] pack2();
    logic [W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*BITS +: BITS] = par2[l];
    return v;
  endfunction

  task automatic push1(input int c);
    exp_t e;
    e.data = pack1();
    e.cyc  = c;
    q1.push_back(e);
  endtask

  task automatic push2(input int c);
    exp_t e;
    e.data = pack2();
    e.cyc  = c;
    q2.push_back(e);
  endtask

  initial begin
    int t, r, r0, s0;
    for (int l = 0; l < LANES; l++) begin
      par1[l] = '0;
      par2[l] = '0;
      chain1[l] = '0;
      chain2[l] = '0;
    end
    bus2.scan_en = 1'b0;

    // 1: reset held with a scan request pending.
    bus1.scan_en = 1'b1;
    repeat (4) tick();
    check("reset rclk", W'(bus1.serial_in_rclk), '0);
    check("reset shldn", W'(bus1.serial_in_shldn), W'(1));
    check("reset data_out", bus1.data_out, '0);
    check("reset data_valid", W'(bus1.data_valid), '0);
    check("reset busy", W'(bus1.busy), '0);
    check("reset dut2 shldn", W'(bus2.serial_in_shldn), W'(1));
    check("reset rclk rises", W'(rises1 + rises2), '0);
    bus1.scan_en = 1'b0;
    resetn = 1'b1;
    repeat (3) tick();
    check("idle busy", W'(bus1.busy), '0);

    // 2: single scan, CLK_DIV = 2.
    par1[LANE_REG_C_LO] = 16'hA5C3;
    par1[LANE_REG_C_HI] = 16'h7FFF;
    par1[LANE_SEL]      = 16'h0001;
    par1[LANE_STRT_HI]  = 16'h8000;
    par1[LANE_CMP]      = 16'h0ABC;
    r0 = rises1;
    s0 = shl_low1;
    t = cyc;
    bus1.scan_en = 1'b1;
    push1(t + 65);
    tick();
    bus1.scan_en = 1'b0;
    wait_until(t + 70);
    check("single scan rclk rises", W'(rises1 - r0), W'(15));
    check("single scan shldn low cycles", W'(shl_low1 - s0), W'(2));

    // 3: continuous scanning, lane0 changed between scans.
    par1[LANE_REG_C_LO] = 16'h1234;
    t = cyc;
    bus1.scan_en = 1'b1;
    push1(t + 65);
    wait_until(t + 65);
    par1[LANE_REG_C_LO] = 16'h4321;
    push1(t + 131);
    wait_until(t + 131);
    bus1.scan_en = 1'b0;
    wait_until(t + 140);

    // 4: scan_en dropped mid-scan.
    s0 = shl_low1;
    t = cyc;
    bus1.scan_en = 1'b1;
    push1(t + 65);
    wait_until(t + 20);
    bus1.scan_en = 1'b0;
    wait_until(t + 100);
    check("drop busy after scan", W'(bus1.busy), '0);
    check("drop shldn low cycles", W'(shl_low1 - s0), W'(2));

    // 5: reset 30 cycles into a scan, then a fresh scan.
    par1[LANE_STRT_HI] = 16'hC3A5;
    t = cyc;
    bus1.scan_en = 1'b1;
    wait_until(t + 30);
    resetn = 1'b0;
    #1;
    check("midscan reset busy", W'(bus1.busy), '0);
    check("midscan reset rclk", W'(bus1.serial_in_rclk), '0);
    check("midscan reset shldn", W'(bus1.serial_in_shldn), W'(1));
    check("midscan reset data_out", bus1.data_out, '0);
    check("midscan reset data_valid", W'(bus1.data_valid), '0);
    repeat (3) tick();
    resetn = 1'b1;
    r = cyc;
    push1(r + 65);
    tick();
    bus1.scan_en = 1'b0;
    wait_until(r + 75);

    // 6: CLK_DIV = 1 boundary.
    par2[LANE_REG_C_LO] = 16'h8001;
    par2[LANE_REG_C_HI] = 16'h0000;
    par2[LANE_SEL]      = 16'h5555;
    par2[LANE_STRT_HI]  = 16'hFFFE;
    par2[LANE_CMP]      = 16'h0FFF;
    r0 = rises2;
    t = cyc;
    bus2.scan_en = 1'b1;
    push2(t + 33);
    tick();
    bus2.scan_en = 1'b0;
    wait_until(t + 40);
    check("div1 rclk rises", W'(rises2 - r0), W'(15));

    check("dut1 missing data_valid", W'(q1.size()), '0);
    check("dut2 missing data_valid", W'(q2.size()), '0);
    check("dut1 data_out changed between pulses", W'(unstable1), '0);
    check("dut2 data_out changed between pulses", W'(unstable2), '0);
    check("dut1 rclk high while shldn low", W'(overlap1), '0);
    check("dut2 rclk high while shldn low", W'(overlap2), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
